// File: rtl/abacus_pkg.sv
// rtl/abacus_pkg.sv - shared ABACUS profiler register map constants and sampler state type
package abacus_pkg;

  // Register map shared with the ABACUS register slave
  localparam logic [31:0] ABACUS_BASE_ADDR_DEFAULT = 32'hf003_0000;
  localparam logic [15:0] ABACUS_ENABLE_OFFSET     = 16'h0004;
  localparam logic [15:0] ABACUS_ENABLE2_OFFSET    = 16'h0008;
  localparam logic [15:0] ABACUS_INSTR_BASE        = 16'h0100;
  localparam logic [15:0] ABACUS_CACHE_BASE        = 16'h0200;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_FIN  = 2'd3
  } sampler_state_e;

  // Byte address of a register given the map base and its offset; wraps modulo 2^32
  function automatic logic [31:0] abacus_reg_addr(input logic [31:0] base, input logic [15:0] offset);
    return base + {16'h0000, offset};
  endfunction

endpackage

// File: rtl/abacus_period_timer.sv
// rtl/abacus_period_timer.sv - free-running 0..PERIOD-1 counter with a wrap pulse
module abacus_period_timer #(
  parameter int unsigned PERIOD = 20
) (
  input  logic clk,
  input  logic rst,
  output logic expire
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero after the last value; never pauses
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry is the cycle whose edge wraps the counter back to zero
  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/abacus_wb_sampler.sv
// rtl/abacus_wb_sampler.sv - Wishbone initiator sweeping ABACUS counters into a word stream
module abacus_wb_sampler
  import abacus_pkg::*;
#(
  parameter logic [31:0] ABACUS_BASE_ADDR = ABACUS_BASE_ADDR_DEFAULT,
  parameter logic [15:0] FIRST_OFFSET     = ABACUS_INSTR_BASE,
  parameter int unsigned NUM_WORDS        = 11,
  parameter int unsigned PERIOD_CYCLES    = 0,
  parameter int unsigned ACK_TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        overrun,
  input  logic        clear_status,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [7:0]  m_index,
  output logic        m_last
);

  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);
  localparam logic [7:0]    LAST_IDX  = 8'(NUM_WORDS - 1);
  localparam logic [31:0]   FIRST_ADR = abacus_reg_addr(ABACUS_BASE_ADDR, FIRST_OFFSET);

  sampler_state_e state_q, state_d;
  logic [7:0]     idx_q, idx_d;
  logic [31:0]    addr_q, addr_d;
  logic [AW-1:0]  ack_cnt_q, ack_cnt_d;
  logic [31:0]    data_q, data_d;
  logic           error_q, error_d;
  logic           overrun_q, overrun_d;
  logic           timer_expire;
  logic           req;

  // Optional periodic sweep trigger; zero period means start-only operation
  generate
    if (PERIOD_CYCLES > 0) begin : g_timer
      abacus_period_timer #(
        .PERIOD (PERIOD_CYCLES)
      ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .expire (timer_expire)
      );
    end else begin : g_no_timer
      assign timer_expire = 1'b0;
    end
  endgenerate

  // start and timer expiry in the same cycle merge into one request
  assign req = start | timer_expire;

  // Sweep sequencing, ack timeout, and sticky status; a set beats clear_status
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    ack_cnt_d = ack_cnt_q;
    data_d    = data_q;
    error_d   = clear_status ? 1'b0 : error_q;
    overrun_d = clear_status ? 1'b0 : overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d   = S_REQ;
          idx_d     = 8'd0;
          addr_d    = FIRST_ADR;
          ack_cnt_d = '0;
          error_d   = 1'b0;
        end
      end
      S_REQ: begin
        // stb is high throughout REQ, so ack alone qualifies the data sample
        if (wb_ack) begin
          data_d  = wb_dat_i;
          state_d = S_HOLD;
        end else if (ack_cnt_q == ACK_LAST) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            idx_d     = idx_q + 8'd1;
            addr_d    = addr_q + 32'd4;
            ack_cnt_d = '0;
            state_d   = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (req && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      addr_q    <= 32'd0;
      ack_cnt_q <= '0;
      data_q    <= 32'd0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      ack_cnt_q <= ack_cnt_d;
      data_q    <= data_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign error    = error_q;
  assign overrun  = overrun_q;
  assign wb_cyc   = (state_q == S_REQ);
  assign wb_stb   = (state_q == S_REQ);
  assign wb_we    = 1'b0;
  assign wb_dat_o = 32'd0;
  assign wb_adr   = addr_q;
  assign m_valid  = (state_q == S_HOLD);
  assign m_data   = data_q;
  assign m_index  = idx_q;
  assign m_last   = (state_q == S_HOLD) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_abacus_wb_sampler.sv
// tb/tb_abacus_wb_sampler.sv - directed self-checking bench for abacus_wb_sampler
module tb_abacus_wb_sampler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Start-triggered instance (default parameters, timer disabled)
  logic        start = 1'b0, clear_status = 1'b0;
  logic        busy, done, error, overrun;
  logic        wb_cyc, wb_stb, wb_we, wb_ack;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        m_valid, m_last;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic [7:0]  m_index;
  logic        stall_en = 1'b0;
  logic [31:0] stall_adr = 32'hf003_0108;

  // Timer-triggered instance: 4 words every 20 cycles
  logic        start_t = 1'b0, clear_t = 1'b0;
  logic        busy_t, done_t, error_t, overrun_t;
  logic        cyc_t, stb_t, we_t, ack_t;
  logic [31:0] adr_t, dato_t, dati_t;
  logic        mv_t, ml_t;
  logic        mr_t = 1'b1;
  logic [31:0] md_t;
  logic [7:0]  mi_t;

  abacus_wb_sampler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .overrun(overrun), .clear_status(clear_status), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack(wb_ack), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .m_last(m_last)
  );

  abacus_wb_sampler #(.NUM_WORDS(4), .PERIOD_CYCLES(20)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .busy(busy_t), .done(done_t), .error(error_t),
    .overrun(overrun_t), .clear_status(clear_t), .wb_cyc(cyc_t), .wb_stb(stb_t),
    .wb_we(we_t), .wb_adr(adr_t), .wb_dat_o(dato_t), .wb_dat_i(dati_t),
    .wb_ack(ack_t), .m_valid(mv_t), .m_ready(mr_t), .m_data(md_t),
    .m_index(mi_t), .m_last(ml_t)
  );

  // Slave memory: word at 0xf0030100 + 4*i holds i+1
  function automatic logic [31:0] slave_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'hf003_0100;
    return (off < 32'd64) ? ((off >> 2) + 32'd1) : 32'hdead_beef;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) wb_ack <= 1'b0;
    else     wb_ack <= wb_stb & ~wb_ack & ~(stall_en & (wb_adr == stall_adr));
  end
  assign wb_dat_i = slave_word(wb_adr);

  always @(posedge clk or posedge rst) begin
    if (rst) ack_t <= 1'b0;
    else     ack_t <= stb_t & ~ack_t;
  end
  assign dati_t = slave_word(adr_t);

  // Reference phase of the 20-cycle timer; expiry is the cycle it reads 19
  int tb_tcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_tcnt <= 0;
    else     tb_tcnt <= (tb_tcnt == 19) ? 0 : tb_tcnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int w_words, w_last_cnt, w_last_cyc, w_done_cnt, w_done_cyc, w_first_valid;
  int w_first_stb, w_stb_last, w_acks, w_adr_bad, w_order_bad, w_stable_bad, w_cycstb_bad;

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Observes the main instance for ncyc cycles after a kick (cycle 0 = start cycle)
  task automatic watch(input int ncyc, input int rdy_mode);
    logic pend;
    logic [31:0] pd;
    logic [7:0] pi;
    pend = 1'b0; pd = '0; pi = '0;
    w_words = 0; w_last_cnt = 0; w_last_cyc = -1; w_done_cnt = 0; w_done_cyc = -1;
    w_first_valid = -1; w_first_stb = -1; w_stb_last = -1; w_acks = 0;
    w_adr_bad = 0; w_order_bad = 0; w_stable_bad = 0; w_cycstb_bad = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      m_ready = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 1);
      if (wb_cyc !== wb_stb) w_cycstb_bad++;
      if (wb_stb) begin
        if (w_first_stb < 0) w_first_stb = c;
        w_stb_last = c;
      end
      if (wb_stb && wb_ack) begin
        if (wb_adr !== 32'hf003_0100 + 32'(4 * w_acks)) w_adr_bad++;
        w_acks++;
      end
      if (m_valid) begin
        if (w_first_valid < 0) w_first_valid = c;
        if (pend && (m_data !== pd || m_index !== pi)) w_stable_bad++;
        if (m_ready) begin
          if (m_data !== 32'(w_words + 1) || m_index !== 8'(w_words)) w_order_bad++;
          if (m_last) begin
            w_last_cnt++;
            w_last_cyc = c;
          end
          w_words++;
          pend = 1'b0;
        end else begin
          pend = 1'b1; pd = m_data; pi = m_index;
        end
      end
      if (done) begin
        w_done_cnt++;
        w_done_cyc = c;
      end
    end
    m_ready = 1'b1;
  endtask

  int rises, exp_rises, rise_bad, dn, pt;
  logic pb, found;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 0);
    chk("rst_we_dato", {31'd0, wb_we} | wb_dat_o, 0);
    chk("rst_adr", wb_adr, 0);
    chk("rst_valid_last", {30'd0, m_valid, m_last}, 0);
    chk("rst_data", m_data, 0);
    chk("rst_index", 32'(m_index), 0);
    chk("rst_t_outs", {24'd0, busy_t, done_t, error_t, overrun_t, cyc_t, we_t, mv_t, ml_t}, 0);
    @(negedge clk);
    rst = 1'b0;

    // T1: full sweep, m_ready held high
    kick();
    watch(40, 0);
    chk("t1_first_stb", w_first_stb, 1);
    chk("t1_first_valid", w_first_valid, 3);
    chk("t1_words", w_words, 11);
    chk("t1_order", w_order_bad, 0);
    chk("t1_adr", w_adr_bad, 0);
    chk("t1_acks", w_acks, 11);
    chk("t1_last_cnt", w_last_cnt, 1);
    chk("t1_last_cyc", w_last_cyc, 33);
    chk("t1_done_cyc", w_done_cyc, 34);
    chk("t1_done_cnt", w_done_cnt, 1);
    chk("t1_cyc_eq_stb", w_cycstb_bad, 0);
    chk("t1_error", 32'(error), 0);

    // T2: m_ready toggling; word k accepted at cycle 3+4k
    kick();
    watch(70, 1);
    chk("t2_words", w_words, 11);
    chk("t2_order", w_order_bad, 0);
    chk("t2_stable", w_stable_bad, 0);
    chk("t2_acks", w_acks, 11);
    chk("t2_last_cnt", w_last_cnt, 1);
    chk("t2_done_cyc", w_done_cyc, 44);

    // T3: no ack at 0xf0030108; word 2 stb from cycle 7 through 22
    stall_en = 1'b1;
    kick();
    watch(30, 0);
    stall_en = 1'b0;
    chk("t3_words", w_words, 2);
    chk("t3_acks", w_acks, 2);
    chk("t3_stb_last", w_stb_last, 22);
    chk("t3_done_cyc", w_done_cyc, 23);
    chk("t3_done_cnt", w_done_cnt, 1);
    chk("t3_no_last", w_last_cnt, 0);
    chk("t3_error", 32'(error), 1);

    // T5: reset during REQ of word 5 (stb at cycle 16)
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("t5_stb_w5", 32'(wb_stb), 1);
    chk("t5_idx_w5", 32'(m_index), 5);
    chk("t5_adr_w5", wb_adr, 32'hf003_0114);
    rst = 1'b1;
    #1;
    chk("t5_cyc_async", 32'(wb_cyc), 0);
    chk("t5_busy_async", 32'(busy), 0);
    chk("t5_valid_async", 32'(m_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_idle", {30'd0, busy, done}, 0);
    chk("t5_post_err", 32'(error), 0);
    kick();
    watch(40, 0);
    chk("t5_words", w_words, 11);
    chk("t5_order", w_order_bad, 0);
    chk("t5_done_cyc", w_done_cyc, 34);

    // T4: timer sweeps every 20 cycles with m_ready high
    rises = 0; exp_rises = 0; rise_bad = 0;
    pb = busy_t; pt = tb_tcnt;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (busy_t & ~pb) rises++;
      if (pt == 19) exp_rises++;
      if ((busy_t & ~pb) != (pt == 19)) rise_bad++;
      pb = busy_t; pt = tb_tcnt;
    end
    chk("t4_rises", rises, exp_rises);
    chk("t4_rise_timing", rise_bad, 0);
    chk("t4_overrun0", 32'(overrun_t), 0);
    chk("t4_error0", 32'(error_t), 0);

    // T4: stall the stream for 30 cycles from the start of a sweep
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (busy_t & ~pb) found = 1'b1;
      pb = busy_t;
    end
    chk("t4_sweep_seen", 32'(found), 1);
    mr_t = 1'b0;
    dn = 0;
    for (int c = 2; c <= 31; c++) begin
      @(negedge clk);
      if (done_t) dn++;
    end
    chk("t4_hold_done", dn, 0);
    chk("t4_hold_word0", {23'd0, mv_t, mi_t}, 32'h100);
    chk("t4_overrun1", 32'(overrun_t), 1);
    mr_t = 1'b1;
    dn = 0; rises = 0; pb = busy_t;
    for (int c = 32; c <= 56; c++) begin
      @(negedge clk);
      if (busy_t & ~pb) rises++;
      if (done_t) dn++;
      pb = busy_t;
    end
    chk("t4_drain_done", dn, 1);
    chk("t4_dropped_no_sweep", rises, 0);

    // T6: clear, then start coinciding with expiry, then clear+start while busy
    @(negedge clk);
    clear_t = 1'b1;
    @(negedge clk);
    clear_t = 1'b0;
    @(negedge clk);
    chk("t6_cleared", 32'(overrun_t), 0);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (tb_tcnt == 19 && !busy_t) found = 1'b1;
    end
    chk("t6_aligned", 32'(found), 1);
    start_t = 1'b1;
    rises = 0; dn = 0; pb = busy_t;
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) start_t = 1'b0;
      if (c == 2) chk("t6_no_overrun", 32'(overrun_t), 0);
      if (c == 3) begin
        start_t = 1'b1;
        clear_t = 1'b1;
      end
      if (c == 4) begin
        start_t = 1'b0;
        clear_t = 1'b0;
        chk("t6_set_wins", 32'(overrun_t), 1);
      end
      if (busy_t & ~pb) rises++;
      if (done_t) dn++;
      pb = busy_t;
    end
    chk("t6_one_sweep", rises, 1);
    chk("t6_one_done", dn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
